// File: rtl/rmw_mem_pkg.sv
// Shared state encoding, byte-merge and clog2 helpers for the RMW memory slave.
package rmw_mem_pkg;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_WAIT = 3'd1;
  localparam logic [2:0] WR      = 3'd2;
  localparam logic [2:0] RMW_RD  = 3'd3;
  localparam logic [2:0] RMW_WR  = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Sized for the widest supported word; callers zero-extend and truncate.
  function automatic logic [63:0] merge_bytes(input logic [7:0]  strb,
                                              input logic [63:0] new_word,
                                              input logic [63:0] old_word);
    logic [63:0] m;
    for (int i = 0; i < 8; i++)
      m[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    return m;
  endfunction

endpackage

// File: rtl/rmw_sp_ram.sv
// Single-port synchronous RAM without byte enables; read latency 1 or 2.
// Vendor BSRAM primitives get swapped in here.
module rmw_sp_ram
  import rmw_mem_pkg::*;
#(
  parameter int    DATA_W   = 32,
  parameter int    DEPTH    = 4096,
  parameter int    RD_LAT   = 1,
  parameter string INITFILE = "none",
  localparam int   ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) mem[addr] <= din;
      else    rd_q      <= mem[addr];
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DATA_W-1:0] rd_q2;
      always_ff @(posedge clk) rd_q2 <= rd_q;
      assign dout = rd_q2;
    end else begin : g_lat1
      assign dout = rd_q;
    end
  endgenerate

endmodule

// File: rtl/rmw_mem_ctrl.sv
// Native-bus memory slave: full writes go straight to RAM, partial writes run read-modify-write.
// Optional performance counters under RMW_MEM_PERF_CNT_EN.
module rmw_mem_ctrl
  import rmw_mem_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         DEPTH    = 4096,
  parameter logic [3:0] BASE     = 4'h2,
  parameter int         RD_LAT   = 1,
  parameter string      INITFILE = "none",
  localparam int        STRB_W   = DATA_W / 8,
  localparam int        IDX_W    = clog2(DEPTH),
  localparam int        OFS_W    = clog2(STRB_W)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [STRB_W-1:0] mem_wstrb,
  output logic              mem_ready,
  output logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       cnt_rd,
  output logic [31:0]       cnt_wr,
  output logic [31:0]       cnt_rmw
);

  logic [2:0]        state, state_nxt;
  logic [1:0]        lat_cnt;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] strb_q;
  logic              oor_q;
  logic [DATA_W-1:0] data_q;

  logic              hit, in_range, full, accept, lat_done;
  logic [IDX_W-1:0]  idx;
  logic              addr_unused;

  logic              ram_ce, ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout, merged;

  assign hit         = mem_valid && (mem_addr[31:28] == BASE);
  assign idx         = mem_addr[OFS_W+IDX_W-1:OFS_W];
  assign in_range    = (mem_addr[27:0] >> (OFS_W + IDX_W)) == 28'd0;
  assign full        = &mem_wstrb;
  assign accept      = (state == IDLE) && hit;
  assign lat_done    = (lat_cnt == 2'd0);
  assign addr_unused = ^mem_addr[OFS_W-1:0];

  assign merged = DATA_W'(merge_bytes(8'(strb_q), 64'(wdata_q), 64'(data_q)));

  // Every access type touches the RAM in its accept cycle; only RMW needs a second access.
  always_comb begin
    ram_ce   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = idx;
    ram_din  = mem_wdata;
    if (accept && in_range) begin
      ram_ce = 1'b1;
      ram_we = full;
    end else if ((state == RMW_WR) && !oor_q) begin
      ram_ce   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = idx_q;
      ram_din  = merged;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hit) begin
          if (mem_wstrb == '0) state_nxt = RD_WAIT;
          else if (full)       state_nxt = WR;
          else                 state_nxt = RMW_RD;
        end
      end
      RD_WAIT: if (lat_done) state_nxt = DONE;
      RMW_RD:  if (lat_done) state_nxt = RMW_WR;
      WR:      state_nxt = DONE;
      RMW_WR:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // data_q holds the old word during RMW and the read result for DONE; cleared for writes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      lat_cnt <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      oor_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        idx_q   <= idx;
        wdata_q <= mem_wdata;
        strb_q  <= mem_wstrb;
        oor_q   <= !in_range;
        lat_cnt <= 2'(RD_LAT - 1);
        data_q  <= '0;
      end else if ((state == RD_WAIT) || (state == RMW_RD)) begin
        if (lat_done) data_q  <= oor_q ? '0 : ram_dout;
        else          lat_cnt <= lat_cnt - 2'd1;
      end else if (state == RMW_WR) begin
        data_q <= '0;
      end
    end
  end

  assign mem_ready = (state == DONE);
  assign mem_rdata = mem_ready ? data_q : '0;

  rmw_sp_ram #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RD_LAT   (RD_LAT),
    .INITFILE (INITFILE)
  ) u_ram (
    .clk  (clk),
    .ce   (ram_ce),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

`ifdef RMW_MEM_PERF_CNT_EN
  logic [31:0] rd_q, wr_q, rmw_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      rmw_q <= '0;
    end else if (state == DONE) begin
      if (strb_q == '0) begin
        if (rd_q != '1) rd_q <= rd_q + 32'd1;
      end else if (&strb_q) begin
        if (wr_q != '1) wr_q <= wr_q + 32'd1;
      end else begin
        if (rmw_q != '1) rmw_q <= rmw_q + 32'd1;
      end
    end
  end

  assign cnt_rd  = rd_q;
  assign cnt_wr  = wr_q;
  assign cnt_rmw = rmw_q;
`else
  assign cnt_rd  = '0;
  assign cnt_wr  = '0;
  assign cnt_rmw = '0;
`endif

endmodule

// File: tb/tb_rmw_mem_ctrl.sv
// Scoreboard bench: two instances (RD_LAT 1 and 2) share one request stream.
module tb_rmw_mem_ctrl;
  import rmw_mem_pkg::*;

  localparam int LAT_A = 1;
  localparam int LAT_B = 2;

  typedef struct {
    logic [31:0] rdata;
    int          t;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;

  logic        ready_a, ready_b;
  logic [31:0] rdata_a, rdata_b;
  logic [31:0] cnt_rd_a, cnt_wr_a, cnt_rmw_a, cnt_rd_b, cnt_wr_b, cnt_rmw_b;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rdy_a = 0;
  int   rdy_b = 0;
  int   n_rd = 0;
  int   n_wr = 0;
  int   n_rmw = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  logic [31:0] model [int];

  rmw_mem_ctrl #(.RD_LAT(LAT_A)) dut_a (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready_a), .mem_rdata(rdata_a),
    .cnt_rd(cnt_rd_a), .cnt_wr(cnt_wr_a), .cnt_rmw(cnt_rmw_a)
  );

  rmw_mem_ctrl #(.RD_LAT(LAT_B)) dut_b (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready_b), .mem_rdata(rdata_b),
    .cnt_rd(cnt_rd_b), .cnt_wr(cnt_wr_b), .cnt_rmw(cnt_rmw_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ready_a) begin
      rdy_a++;
      if (q_a.size() == 0) check("spurious_ready_a", 64'(ready_a), 64'(0));
      else begin
        e_a = q_a.pop_front();
        check("latency_a", 64'(cyc - e_a.t), 64'(e_a.lat));
        check("rdata_a", 64'(rdata_a), 64'(e_a.rdata));
      end
    end else check("idle_rdata_a", 64'(rdata_a), 64'(0));
  end

  always @(negedge clk) begin
    if (ready_b) begin
      rdy_b++;
      if (q_b.size() == 0) check("spurious_ready_b", 64'(ready_b), 64'(0));
      else begin
        e_b = q_b.pop_front();
        check("latency_b", 64'(cyc - e_b.t), 64'(e_b.lat));
        check("rdata_b", 64'(rdata_b), 64'(e_b.rdata));
      end
    end else check("idle_rdata_b", 64'(rdata_b), 64'(0));
  end

  // Called at posedge+1; valid is held for the accept cycle only.
  task automatic xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int          idx, la, lb;
    bit          oor;
    logic [31:0] old, nw, exp_rd;
    exp_t        e;
    idx    = int'(a[13:2]);
    oor    = (a[27:14] != '0);
    old    = model.exists(idx) ? model[idx] : 32'h0;
    nw     = old;
    exp_rd = 32'h0;
    if (ws == 4'h0) begin
      n_rd++;
      la = LAT_A + 1;
      lb = LAT_B + 1;
      exp_rd = oor ? 32'h0 : old;
    end else if (ws == 4'hF) begin
      n_wr++;
      la = 2;
      lb = 2;
      nw = wd;
    end else begin
      n_rmw++;
      la = LAT_A + 2;
      lb = LAT_B + 2;
      for (int b = 0; b < 4; b++) if (ws[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
    end
    if (!oor && ws != 4'h0) model[idx] = nw;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = wd;
    mem_wstrb = ws;
    e.rdata = exp_rd;
    e.t     = cyc;
    e.lat   = la;
    q_a.push_back(e);
    e.lat   = lb;
    q_b.push_back(e);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    mem_wdata = 32'h0;
    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
      @(posedge clk); #1;
    end
    if (q_a.size() != 0 || q_b.size() != 0) begin
      check("timeout", 64'(q_a.size() + q_b.size()), 64'(0));
      q_a.delete();
      q_b.delete();
    end
  endtask

  task automatic check_counters(input string tag);
    int er, ew, em;
`ifdef RMW_MEM_PERF_CNT_EN
    er = n_rd;
    ew = n_wr;
    em = n_rmw;
`else
    er = 0;
    ew = 0;
    em = 0;
`endif
    check({tag, "_cnt_rd_a"},  64'(cnt_rd_a),  64'(er));
    check({tag, "_cnt_wr_a"},  64'(cnt_wr_a),  64'(ew));
    check({tag, "_cnt_rmw_a"}, 64'(cnt_rmw_a), 64'(em));
    check({tag, "_cnt_rd_b"},  64'(cnt_rd_b),  64'(er));
    check({tag, "_cnt_wr_b"},  64'(cnt_wr_b),  64'(ew));
    check({tag, "_cnt_rmw_b"}, 64'(cnt_rmw_b), 64'(em));
  endtask

  initial begin
    int ra, rb, kind;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_a", 64'(ready_a), 64'(0));
    check("rst_ready_b", 64'(ready_b), 64'(0));
    check("rst_state_a", 64'(dut_a.state), 64'(IDLE));
    check("rst_state_b", 64'(dut_b.state), 64'(IDLE));
    resetn = 1'b1;
    @(posedge clk); #1;
    check_counters("rst");

    xact(32'h2000_0010, 32'hDEADBEEF, 4'hF);
    xact(32'h2000_0013, 32'h0, 4'h0);
    xact(32'h2000_0020, 32'h11223344, 4'hF);
    xact(32'h2000_0020, 32'hAABBCCDD, 4'b0101);
    xact(32'h2000_0020, 32'h0, 4'h0);

    xact(32'h2000_0000, 32'hCAFEF00D, 4'hF);
    xact(32'h2000_4000, 32'h12345678, 4'hF);
    xact(32'h2000_4000, 32'h0, 4'h0);
    xact(32'h2000_4000, 32'hFFFF_FFFF, 4'b0010);
    xact(32'h2000_0000, 32'h0, 4'h0);

    ra = rdy_a;
    rb = rdy_b;
    mem_valid = 1'b1;
    mem_addr  = 32'h1000_0000;
    mem_wdata = 32'h0BAD_0BAD;
    mem_wstrb = 4'hF;
    repeat (10) @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check("nohit_ready_a", 64'(rdy_a - ra), 64'(0));
    check("nohit_ready_b", 64'(rdy_b - rb), 64'(0));
    xact(32'h2000_0000, 32'h0, 4'h0);

    for (int i = 0; i < 4; i++) xact(32'h2000_0100 + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 20; i++) begin
      a    = 32'h2000_0100 + 32'(4 * $urandom_range(0, 3));
      kind = int'($urandom_range(0, 2));
      if (kind == 0)      xact(a, 32'h0, 4'h0);
      else if (kind == 1) xact(a, $urandom, 4'hF);
      else                xact(a, $urandom, 4'($urandom_range(1, 14)));
    end
    check_counters("mix");

    // Reset lands while both instances sit in RMW_RD of a partial write.
    ra = rdy_a;
    rb = rdy_b;
    mem_valid = 1'b1;
    mem_addr  = 32'h2000_0020;
    mem_wdata = 32'h5566_7788;
    mem_wstrb = 4'b0011;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    check("abort_in_rmw_a", 64'(dut_a.state), 64'(RMW_RD));
    check("abort_in_rmw_b", 64'(dut_b.state), 64'(RMW_RD));
    resetn = 1'b0;
    n_rd   = 0;
    n_wr   = 0;
    n_rmw  = 0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    check("abort_idle_a", 64'(dut_a.state), 64'(IDLE));
    check("abort_idle_b", 64'(dut_b.state), 64'(IDLE));
    check_counters("abort");
    repeat (4) @(posedge clk);
    #1;
    check("abort_ready_a", 64'(rdy_a - ra), 64'(0));
    check("abort_ready_b", 64'(rdy_b - rb), 64'(0));
    xact(32'h2000_0020, 32'h0, 4'h0);
    xact(32'h2000_0010, 32'h0, 4'h0);
    check_counters("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rmw_mem_ctrl.md
Name: rmw_mem_ctrl

Overview:
Parametrised native-bus (valid/ready) memory slave for the picorv32 SoC. It wraps a single-port synchronous RAM that has no byte enables. Full-word writes go straight to the RAM; partial-strobe writes run a read-modify-write sequence. It replaces the fixed 32-bit per-instance RAM/ROM wrappers and supports configurable width, depth, base window, RAM read latency and optional preload.

Parameters:
DATA_W, 32, data width in bits; multiple of 8; allowed 32 or 64.
DEPTH, 4096, number of words; power of two.
BASE, 4'h2, value matched against mem_addr[31:28] to select this slave.
RD_LAT, 1, RAM read latency in cycles; allowed 1 or 2.
INITFILE, "none", hex preload file; "none" means no preload.
Derived constants: STRB_W = DATA_W/8; IDX_W = clog2(DEPTH); OFS_W = clog2(STRB_W).

Ports:
clk  in  1  clock
resetn  in  1  reset, asynchronous, active-low
mem_valid  in  1  request valid; master holds it until mem_ready
mem_addr  in  32  byte address
mem_wdata  in  DATA_W  write data
mem_wstrb  in  STRB_W  byte strobes; all-zero means read
mem_ready  out  1  one-cycle completion pulse
mem_rdata  out  DATA_W  read data; forced to 0 whenever mem_ready=0, so slaves can be OR-combined
cnt_rd  out  32  read count (see Optional Feature)
cnt_wr  out  32  full-write count
cnt_rmw  out  32  partial-write count

Behaviour:
- Reset: mem_ready=0, mem_rdata=0, state=IDLE, counters=0. Asserting reset mid-transaction aborts it; no RAM write is issued after reset assertion; no ready is produced.
- Select: hit = mem_valid && mem_addr[31:28]==BASE. Word index = mem_addr[OFS_W+IDX_W-1:OFS_W]. Low OFS_W bits are ignored.
- Out of range: if mem_addr[27:OFS_W+IDX_W] is nonzero, a read returns 0 and a write is dropped. Ready timing is identical to an in-range access; the bus never hangs.
- Request capture: on accept in IDLE, latch index, wdata and wstrb. The transaction completes even if mem_valid drops; ready is issued regardless.
- FSM:
  - IDLE: on hit:
    - wstrb==0 -> RD_WAIT, RAM read issued.
    - wstrb all-ones -> WR, RAM write issued this cycle.
    - otherwise -> RMW_RD, RAM read issued.
  - RD_WAIT: wait RD_LAT cycles -> DONE, with RAM dout captured into the output register.
  - RMW_RD: wait RD_LAT cycles -> RMW_WR. Merged word: byte i = strb[i] ? wdata byte i : RAM byte i. The merged word is written in RMW_WR.
  - WR, RMW_WR -> DONE.
  - DONE: mem_ready=1 for exactly one cycle -> IDLE. No accept in DONE.
- Latency from accept cycle T:
  - Read: ready at T+RD_LAT+1.
  - Full write: ready at T+2.
  - Partial write: ready at T+RD_LAT+2.
- Back-to-back: a new request may be accepted in the first IDLE cycle after DONE.
- A non-hit while IDLE is ignored; mem_ready stays 0.
- Read-after-partial-write to the same word returns the merged value; no stale data is allowed.

Optional Feature:
- Macro RMW_MEM_PERF_CNT_EN.
- When defined: cnt_rd, cnt_wr and cnt_rmw increment by one in the DONE cycle of the matching transaction type. Out-of-range accesses are counted too. Counters saturate at 32'hFFFF_FFFF and clear only on reset.
- When undefined: the counter ports remain and are tied to 0; no counter flops are inferred.

Decomposition:
- Package rmw_mem_pkg holds:
  - the state enum (IDLE, RD_WAIT, WR, RMW_RD, RMW_WR, DONE);
  - the byte-merge function (strb, new, old -> merged);
  - the clog2 helper.
- Sub-module rmw_sp_ram: single-port sync RAM with DATA_W, DEPTH, RD_LAT and INITFILE parameters; ports ce, we, addr, din, dout. It is the single swap point for vendor BSRAM primitives.

Test Plan:
- Reset, then full write 32'hDEADBEEF to 0x2000_0010, then read it back. Write ready at T+2; read ready at T+2 (RD_LAT=1); rdata=32'hDEADBEEF, and 0 in every other cycle.
- Word holds 32'h11223344; partial write wstrb=4'b0101, wdata=32'hAABBCCDD. Ready at T+3; readback 32'h11BB33DD. Repeat with RD_LAT=2: ready at T+4.
- Address 0x1000_0000 (BASE=2) with valid: mem_ready stays 0 for 10 cycles and the RAM is untouched.
- Address 0x2000_4000 with DEPTH=4096 (out of range): write dropped with ready at T+2; read returns 0; word 0 is unchanged.
- Assert resetn low during RMW_RD of a partial write: target word is unchanged afterwards; no ready pulse; FSM is in IDLE after release.
- With RMW_MEM_PERF_CNT_EN, run 3 reads, 2 full writes and 1 partial write: counters read 3/2/1. Without the macro: all counters read 0.
